sc1602_text_source: RTL

//  Character/command source sitting directly upstream of the SC1602 LCD driver (lcd_driver_8).

---
 rtl/sc1602_text_source.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sc1602_text_source.sv
// sc1602_text_source: host-writable message buffer feeding lcd_driver_8 one character per draw slot,
// plus a periodic window-shift command source using the driver's command/ready handshake.
module sc1602_text_source #(
  parameter int CLK_HZ   = 27_000_000,
  parameter int SHIFT_MS = 500,
  parameter int DEPTH    = 32
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [5:0] msg_len,
  input  logic       scroll_en,
  input  logic       scroll_dir,
  input  logic       drawing,
  input  logic       ready,
  output logic [7:0] character,
  output logic [2:0] command,
  output logic [4:0] char_index,
  output logic       frame_start
);

  localparam int TICKS = CLK_HZ / 1000 * SHIFT_MS;
  localparam int TW    = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [5:0] DEPTH_L = 6'(DEPTH);

  typedef enum logic [1:0] {S_WAIT, S_REQ, S_ACK} state_t;

  // The buffer powers up as spaces and is deliberately untouched by reset.
  logic [7:0] mem [DEPTH] = '{default: 8'h20};

  logic          drawing_m, drawing_s, drawing_d;
  logic          ready_m, ready_s;
  logic          draw_done;
  logic [5:0]    eff_len;
  logic          wrap;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  state_t        state, state_nxt;
  logic          dir_q, dir_nxt;
  logic [2:0]    command_nxt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      drawing_m <= 1'b0;
      drawing_s <= 1'b0;
      drawing_d <= 1'b0;
      ready_m   <= 1'b0;
      ready_s   <= 1'b0;
    end else begin
      drawing_m <= drawing;
      drawing_s <= drawing_m;
      drawing_d <= drawing_s;
      ready_m   <= ready;
      ready_s   <= ready_m;
    end
  end

  assign draw_done = drawing_d & ~drawing_s;

  always_comb begin
    eff_len = msg_len;
    if (msg_len == 6'd0 || msg_len > DEPTH_L) eff_len = DEPTH_L;
  end

  // ">=" rather than "==" so an index stranded past a shrunken length still returns to 0.
  assign wrap = ({1'b0, char_index} >= (eff_len - 6'd1));

  always_ff @(posedge sys_clk) begin
    if (wr_en && ({1'b0, wr_addr} < DEPTH_L)) mem[wr_addr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      char_index  <= 5'd0;
      frame_start <= 1'b0;
      character   <= 8'h20;
    end else begin
      frame_start <= 1'b0;
      character   <= mem[char_index[AW-1:0]];
      if (draw_done) begin
        if (wrap) begin
          char_index  <= 5'd0;
          frame_start <= 1'b1;
        end else begin
          char_index <= char_index + 5'd1;
        end
      end
    end
  end

  assign tick = (tick_cnt == TW'(TICKS - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  tick_cnt <= '0;
    else if (tick)   tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + TW'(1);
  end

  // Handshake: a non-zero command is the request; the driver raising ready means it has seen it,
  // and ready dropping afterwards means it has consumed it, at which point the request is withdrawn.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= S_WAIT;
      dir_q   <= 1'b0;
      command <= 3'b000;
    end else begin
      state   <= state_nxt;
      dir_q   <= dir_nxt;
      command <= command_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    dir_nxt     = dir_q;
    command_nxt = command;
    case (state)
      S_WAIT: begin
        command_nxt = 3'b000;
        if (tick && scroll_en) begin
          state_nxt   = S_REQ;
          dir_nxt     = scroll_dir;
          command_nxt = {2'b01, scroll_dir};
        end
      end
      S_REQ: begin
        command_nxt = {2'b01, dir_q};
        if (ready_s) state_nxt = S_ACK;
      end
      S_ACK: begin
        if (!ready_s) begin
          state_nxt   = S_WAIT;
          command_nxt = 3'b000;
        end
      end
      default: begin
        state_nxt   = S_WAIT;
        command_nxt = 3'b000;
      end
    endcase
  end

endmodule
